// File: rtl/rr_decode_sched.sv
// rr_decode_sched: round-robin owner select driving a 2-to-4 decoder with one-hot grant
module rr_decode_sched #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  input  logic done,
  output logic s0,
  output logic s1,
  output logic en,
  output logic gnt0,
  output logic gnt1,
  output logic gnt2,
  output logic gnt3,
  output logic timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t r_state, w_next;
  logic [1:0] r_sel, r_last, w_i1, w_i2, w_i3, w_win;
  logic [3:0] r_gnt, w_req;
  logic [CNT_W-1:0] r_cnt;
  logic r_timeout, w_found, w_own, w_max, w_release, w_tout;
  assign w_req     = {req3, req2, req1, req0};
  assign w_i1      = r_last + 2'd1;
  assign w_i2      = r_last + 2'd2;
  assign w_i3      = r_last + 2'd3;
  assign w_found   = |w_req;
  assign w_win     = w_req[w_i1] ? w_i1 : w_req[w_i2] ? w_i2 : w_req[w_i3] ? w_i3 : r_last;
  assign w_own     = w_req[r_sel];
  assign w_max     = r_cnt == CNT_W'(MAX_HOLD - 1);
  assign w_release = done | ~w_own | w_max;
  assign {s1, s0}  = r_sel;
  assign {gnt3, gnt2, gnt1, gnt0} = r_gnt;
  assign en        = |r_gnt;
  assign timeout   = r_timeout;
  // next state and forced-release detection; timeout only when the hold limit alone ends the grant
  always_comb begin
    w_next = r_state;
    w_tout = 1'b0;
    if (r_state == IDLE) w_next = w_found ? GRANT : IDLE;
    else begin
      w_next = w_release ? IDLE : GRANT;
      w_tout = w_max & w_own & ~done;
    end
  end
  // state, owner, grant and hold counter registers; a release always passes through IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sel     <= 2'd0;
      r_last    <= 2'd3;
      r_cnt     <= '0;
      r_gnt     <= 4'b0000;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_timeout <= w_tout;
      if (r_state == IDLE) begin
        if (w_found) begin
          r_sel <= w_win;
          r_gnt <= 4'b0001 << w_win;
          r_cnt <= '0;
        end
      end else if (w_release) begin
        r_gnt  <= 4'b0000;
        r_last <= r_sel;
        r_cnt  <= '0;
      end else r_cnt <= w_max ? r_cnt : r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_rr_decode_sched.sv
// tb_rr_decode_sched: scoreboard bench for the round-robin decoder scheduler
module tb_rr_decode_sched;
  logic clk = 1'b0;
  logic rst_n, req0, req1, req2, req3, done;
  logic s0, s1, en, gnt0, gnt1, gnt2, gnt3, timeout;
  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  rr_decode_sched #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .req2(req2), .req3(req3),
    .done(done), .s0(s0), .s1(s1), .en(en), .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2),
    .gnt3(gnt3), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // expected output word: {timeout, en, s1, s0, gnt3..gnt0}
  function automatic logic [7:0] G(logic [1:0] n);
    return {1'b0, 1'b1, n, 4'b0001 << n};
  endfunction
  function automatic logic [7:0] I(logic [1:0] n, logic t);
    return {t, 1'b0, n, 4'b0000};
  endfunction

  // stimulus word: {rst_n, done, req3..req0}
  task automatic drive(logic [5:0] s);
    {rst_n, done, req3, req2, req1, req0} = s;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [5:0] st[$];
    logic [7:0] ex[$];
    logic [7:0] got, e;
    st.push_back(6'b01_1111); ex.push_back(8'h00);
    st.push_back(6'b00_0100); ex.push_back(8'h00);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      tick();
      got = {timeout, en, s1, s0, gnt3, gnt2, gnt1, gnt0};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset step %0d got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_single;
    logic [5:0] st[$];
    logic [7:0] ex[$];
    logic [7:0] got, e;
    for (int k = 0; k < 3; k++) begin st.push_back(6'b10_0100); ex.push_back(G(2'd2)); end
    st.push_back(6'b11_0100); ex.push_back(I(2'd2, 1'b0));
    st.push_back(6'b11_0000); ex.push_back(I(2'd2, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      tick();
      got = {timeout, en, s1, s0, gnt3, gnt2, gnt1, gnt0};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL single step %0d got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_round_robin;
    logic [5:0] st[$];
    logic [7:0] ex[$];
    logic [7:0] got, e;
    st.push_back(6'b00_1111); ex.push_back(8'h00);
    for (int k = 0; k < 5; k++) begin
      st.push_back(6'b10_1111); ex.push_back(G(k[1:0]));
      st.push_back(6'b11_1111); ex.push_back(I(k[1:0], 1'b0));
    end
    st.push_back(6'b10_0000); ex.push_back(I(2'd0, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      tick();
      got = {timeout, en, s1, s0, gnt3, gnt2, gnt1, gnt0};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL round_robin step %0d got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_timeout;
    logic [5:0] st[$];
    logic [7:0] ex[$];
    logic [7:0] got, e;
    st.push_back(6'b00_0000); ex.push_back(8'h00);
    for (int k = 0; k < 8; k++) begin st.push_back(6'b10_0010); ex.push_back(G(2'd1)); end
    st.push_back(6'b10_0010); ex.push_back(I(2'd1, 1'b1));
    st.push_back(6'b10_0010); ex.push_back(G(2'd1));
    for (int k = 0; k < 7; k++) begin st.push_back(6'b10_1010); ex.push_back(G(2'd1)); end
    st.push_back(6'b10_1010); ex.push_back(I(2'd1, 1'b1));
    st.push_back(6'b10_1010); ex.push_back(G(2'd3));
    st.push_back(6'b10_0000); ex.push_back(I(2'd3, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      tick();
      got = {timeout, en, s1, s0, gnt3, gnt2, gnt1, gnt0};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL timeout step %0d got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_owner_drop;
    logic [5:0] st[$];
    logic [7:0] ex[$];
    logic [7:0] got, e;
    st.push_back(6'b00_0000); ex.push_back(8'h00);
    for (int k = 0; k < 3; k++) begin st.push_back(6'b10_0011); ex.push_back(G(2'd0)); end
    st.push_back(6'b10_0010); ex.push_back(I(2'd0, 1'b0));
    st.push_back(6'b10_0010); ex.push_back(G(2'd1));
    st.push_back(6'b11_0010); ex.push_back(I(2'd1, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      tick();
      got = {timeout, en, s1, s0, gnt3, gnt2, gnt1, gnt0};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL owner_drop step %0d got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_done_at_limit;
    logic [5:0] st[$];
    logic [7:0] ex[$];
    logic [7:0] got, e;
    st.push_back(6'b00_0000); ex.push_back(8'h00);
    for (int k = 0; k < 8; k++) begin st.push_back(6'b10_0100); ex.push_back(G(2'd2)); end
    st.push_back(6'b11_0100); ex.push_back(I(2'd2, 1'b0));
    for (int k = 0; k < 8; k++) begin st.push_back(6'b10_0100); ex.push_back(G(2'd2)); end
    st.push_back(6'b10_0000); ex.push_back(I(2'd2, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      tick();
      got = {timeout, en, s1, s0, gnt3, gnt2, gnt1, gnt0};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL done_at_limit step %0d got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_reset_mid_grant;
    logic [5:0] st[$];
    logic [7:0] ex[$];
    logic [7:0] got, e;
    st.push_back(6'b00_0000); ex.push_back(8'h00);
    st.push_back(6'b10_1000); ex.push_back(G(2'd3));
    st.push_back(6'b10_1000); ex.push_back(G(2'd3));
    st.push_back(6'b00_1000); ex.push_back(8'h00);
    st.push_back(6'b10_1001); ex.push_back(G(2'd0));
    st.push_back(6'b11_1001); ex.push_back(I(2'd0, 1'b0));
    st.push_back(6'b10_1001); ex.push_back(G(2'd3));
    st.push_back(6'b11_1001); ex.push_back(I(2'd3, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      tick();
      got = {timeout, en, s1, s0, gnt3, gnt2, gnt1, gnt0};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_mid_grant step %0d got %b expected %b", i, got, e);
      end
    end
  endtask

  initial begin
    drive(6'b00_0000);
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_owner_drop();
    test_done_at_limit();
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_decode_sched.md
Name: rr_decode_sched

Overview:
- Round-robin scheduler for the 2-to-4 select decoder (`decodelow`).
- Four requesters share one decoded resource.
- The block chooses a winner and drives the decoder selects `s1`/`s0` plus a matching registered one-hot grant.
- It holds the grant until the owner finishes, drops its request, or times out, then passes ownership to the next requester in circular order.

Parameters:
- MAX_HOLD, 8: maximum number of cycles a grant may be held before forced release. Legal range 2..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req0  in  1  request from requester 0.
- req1  in  1  request from requester 1.
- req2  in  1  request from requester 2.
- req3  in  1  request from requester 3.
- done  in  1  current owner finished; only meaningful in GRANT.
- s0  out  1  decoder select LSB (registered).
- s1  out  1  decoder select MSB (registered); {s1,s0} = index of the current owner.
- en  out  1  high while a grant is active; decoder output is valid only when en=1.
- gnt0..gnt3  out  1 each  registered one-hot grant; gntN=1 iff en=1 and {s1,s0}=N.
- timeout  out  1  one-cycle pulse marking a forced release.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, s0=s1=0, en=0, gnt0..3=0, timeout=0, hold counter=0.
  - last-owner pointer=3, so requester 0 has top priority after reset.
  - Applies even mid-GRANT; no grant survives reset.
- State machine has two states, IDLE and GRANT.
- IDLE:
  - Each cycle, search requesters starting at (last+1) mod 4, wrapping circularly.
  - The first with reqN=1 wins.
  - At the next edge: state=GRANT, {s1,s0}=winner, en=1, gnt one-hot=winner, counter=0.
  - Latency from req sampled high to gnt high is exactly 1 cycle.
  - If no requests, stay in IDLE; s0/s1 keep their previous value; en and gnt stay 0.
  - done is ignored in IDLE.
- GRANT:
  - counter increments by 1 per cycle; it saturates at MAX_HOLD-1 and never wraps.
  - Release condition is any of:
    - (a) done=1
    - (b) req of the current owner =0
    - (c) counter==MAX_HOLD-1
  - On release, at the next edge: state=IDLE, en=0, all gnt=0, last=owner, counter=0.
  - timeout=1 for exactly that one cycle only if (c) holds and neither (a) nor (b) holds; otherwise timeout=0.
- Break-before-make: every release is followed by at least one cycle with all gnt=0 before the next grant.
  - Back-to-back ownership changes therefore take 2 cycles per handover.
- Fairness: after release, the releasing requester has lowest priority.
  - With all four requesting continuously, grants cycle 0,1,2,3,0,...
- Requests that change while in GRANT do not affect the current owner (except its own req, rule b).
- Invariants:
  - gnt is always one-hot or all-zero.
  - en = OR(gnt0..gnt3).
  - s0/s1 change only when en rises.

Test Plan:
- Reset then single request: rst_n=0 for 2 cycles, then release; req2=1 at cycle 0 → cycle 1: en=1, s1=1, s0=0, gnt2=1. At cycle 3 done=1 → cycle 4: en=0, gnt all 0, timeout=0.
- All requesting, done pulsed after each grant: req0..3=1 held → grant order 0,1,2,3,0, with exactly one all-zero cycle between consecutive grants.
- Timeout with MAX_HOLD=8: req1=1 held, done=0 → gnt1 high for 8 cycles, then gnt1=0 and timeout=1 for 1 cycle. Next grant goes to 1 again only if no other req is high; with req3=1 also high, the next grant is 3.
- Owner drops request: req0=1 and req1=1; 0 granted; after 2 cycles req0=0 → next edge gnt0=0, timeout=0; one cycle later gnt1=1, {s1,s0}=01.
- Simultaneous done and timeout: done=1 in the same cycle the counter reaches MAX_HOLD-1 → single release, timeout stays 0.
- Reset mid-grant: gnt3=1 active, rst_n=0 for 1 edge → all outputs 0 at that edge. After rst_n=1 with req0=1 and req3=1, requester 0 is granted first (pointer reset to 3).
